// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard/forwarding controller.
package hazard_pkg;

    localparam int unsigned FWD_SEL_REGFILE = 0;
    localparam logic [3:0]  BE_FULL         = 4'hF;

    typedef enum logic [0:0] {
        MC_IDLE,
        MC_BUSY
    } mc_state_t;

    function automatic int unsigned sel_w(input int unsigned nfwd);
        return $clog2(nfwd + 1);
    endfunction

endpackage

// File: rtl/hazard_mc_scoreboard.sv
// HI/LO multi-cycle unit scoreboard: IDLE/BUSY FSM with countdown watchdog
// and sticky timeout flag.
module hazard_mc_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned MC_LAT = 33
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic mc_start_i,
    input  logic mc_done_i,
    output logic mc_busy_o,
    output logic mc_timeout_o
);

    localparam int unsigned     CntW    = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(MC_LAT - 1);

    mc_state_t       state_q;
    logic [CntW-1:0] cnt_q;
    logic            timeout_q;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q   <= MC_IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                MC_IDLE: begin
                    if (mc_start_i) begin
                        state_q <= MC_BUSY;
                        cnt_q   <= CntLoad;
                    end
                end
                MC_BUSY: begin
                    // A done coinciding with a new start hands the unit straight to the next op.
                    if (mc_done_i) begin
                        if (mc_start_i) begin
                            cnt_q <= CntLoad;
                        end else begin
                            state_q <= MC_IDLE;
                        end
                    end else if (cnt_q == '0) begin
                        state_q   <= MC_IDLE;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= MC_IDLE;
            endcase
        end
    end

    assign mc_busy_o    = (state_q == MC_BUSY);
    assign mc_timeout_o = timeout_q;

endmodule

// File: rtl/hazard_fwd_unit.sv
// ID-stage operand bypass select and stall generation for the MIPS pipeline.
// Optional stall-cause perf counters are enabled with HAZ_PERF_CNT_EN.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_RPORTS     = 2,
    parameter int unsigned NUM_FWD        = 3,
    parameter int unsigned REG_AW         = 5,
    parameter int unsigned LOAD_RDY_STAGE = 2,
    parameter int unsigned MC_LAT         = 33,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                                  clk_i,
    input  logic                                  resetn_i,
    input  logic [NUM_RPORTS-1:0]                 rd_valid_i,
    input  logic [NUM_RPORTS*REG_AW-1:0]          rd_addr_i,
    input  logic [NUM_FWD*REG_AW-1:0]             stg_waddr_i,
    input  logic [NUM_FWD*4-1:0]                  stg_wen_i,
    input  logic [NUM_FWD-1:0]                    stg_load_i,
    input  logic                                  id_valid_i,
    input  logic                                  id_uses_hilo_i,
    input  logic                                  mc_start_i,
    input  logic                                  mc_done_i,
    output logic [NUM_RPORTS*sel_w(NUM_FWD)-1:0]  fwd_sel_o,
    output logic                                  stall_id_o,
    output logic                                  pc_we_o,
    output logic                                  ir_we_o,
    output logic                                  mc_busy_o,
    output logic                                  mc_timeout_o
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]                      cnt_load_o,
    output logic [CNT_W-1:0]                      cnt_partial_o,
    output logic [CNT_W-1:0]                      cnt_mc_o
`endif
);

    localparam int unsigned SelW = sel_w(NUM_FWD);

    logic [NUM_RPORTS-1:0] load_hit;
    logic [NUM_RPORTS-1:0] part_hit;
    logic                  load_stall;
    logic                  part_stall;
    logic                  mc_stall;
    logic                  mc_busy;

    for (genvar k = 0; k < NUM_RPORTS; k++) begin : g_port
        logic [REG_AW-1:0] addr;
        logic [SelW-1:0]   sel;
        logic              ld;
        logic              part;

        assign addr = rd_addr_i[k*REG_AW +: REG_AW];

        // Scan oldest to youngest so the youngest matching producer is left standing.
        always_comb begin
            sel  = SelW'(FWD_SEL_REGFILE);
            ld   = 1'b0;
            part = 1'b0;
            for (int j = NUM_FWD - 1; j >= 0; j--) begin
                if (rd_valid_i[k] && (addr != '0) &&
                    (addr == stg_waddr_i[j*REG_AW +: REG_AW]) && (|stg_wen_i[j*4 +: 4])) begin
                    sel  = SelW'(j + 1);
                    ld   = stg_load_i[j] && (j < int'(LOAD_RDY_STAGE));
                    part = (stg_wen_i[j*4 +: 4] != BE_FULL);
                end
            end
        end

        assign fwd_sel_o[k*SelW +: SelW] = sel;
        assign load_hit[k]               = ld;
        assign part_hit[k]               = part;
    end

    hazard_mc_scoreboard #(
        .MC_LAT (MC_LAT)
    ) u_mc_sb (
        .clk_i        (clk_i),
        .resetn_i     (resetn_i),
        .mc_start_i   (mc_start_i),
        .mc_done_i    (mc_done_i),
        .mc_busy_o    (mc_busy),
        .mc_timeout_o (mc_timeout_o)
    );

    assign load_stall = |load_hit;
    assign part_stall = |part_hit;
    assign mc_stall   = id_valid_i & id_uses_hilo_i & mc_busy;
    assign stall_id_o = load_stall | part_stall | mc_stall;
    assign pc_we_o    = ~stall_id_o;
    assign ir_we_o    = ~stall_id_o;
    assign mc_busy_o  = mc_busy;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_load_q;
    logic [CNT_W-1:0] cnt_partial_q;
    logic [CNT_W-1:0] cnt_mc_q;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            cnt_load_q    <= '0;
            cnt_partial_q <= '0;
            cnt_mc_q      <= '0;
        end else begin
            if (load_stall && (cnt_load_q != '1))    cnt_load_q    <= cnt_load_q + 1'b1;
            if (part_stall && (cnt_partial_q != '1)) cnt_partial_q <= cnt_partial_q + 1'b1;
            if (mc_stall && (cnt_mc_q != '1))        cnt_mc_q      <= cnt_mc_q + 1'b1;
        end
    end

    assign cnt_load_o    = cnt_load_q;
    assign cnt_partial_o = cnt_partial_q;
    assign cnt_mc_o      = cnt_mc_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed scenarios plus randomized
// forwarding and scoreboard traffic against a behavioural model.
module tb_hazard_fwd_unit;

    localparam int NRP    = 2;
    localparam int NF     = 3;
    localparam int AW     = 5;
    localparam int SELW   = $clog2(NF + 1);
    localparam int LDRDY  = 2;
    localparam int LAT_A  = 33;
    localparam int LAT_B  = 4;
    localparam int CW     = 32;

    logic                 clk = 1'b0;
    logic                 resetn = 1'b0;
    logic [NRP-1:0]       rd_valid;
    logic [NRP*AW-1:0]    rd_addr;
    logic [NF*AW-1:0]     stg_waddr;
    logic [NF*4-1:0]      stg_wen;
    logic [NF-1:0]        stg_load;
    logic                 id_valid, id_uses_hilo, mc_start, mc_done;

    logic [NRP*SELW-1:0]  sel_a, sel_b;
    logic                 stall_a, pc_we_a, ir_we_a, busy_a, to_a;
    logic                 stall_b, pc_we_b, ir_we_b, busy_b, to_b;
`ifdef HAZ_PERF_CNT_EN
    logic [CW-1:0]        cl_a, cp_a, cm_a, cl_b, cp_b, cm_b;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit #(
        .NUM_RPORTS(NRP), .NUM_FWD(NF), .REG_AW(AW), .LOAD_RDY_STAGE(LDRDY),
        .MC_LAT(LAT_A), .CNT_W(CW)
    ) dut_a (
        .clk_i(clk), .resetn_i(resetn), .rd_valid_i(rd_valid), .rd_addr_i(rd_addr),
        .stg_waddr_i(stg_waddr), .stg_wen_i(stg_wen), .stg_load_i(stg_load),
        .id_valid_i(id_valid), .id_uses_hilo_i(id_uses_hilo), .mc_start_i(mc_start),
        .mc_done_i(mc_done), .fwd_sel_o(sel_a), .stall_id_o(stall_a), .pc_we_o(pc_we_a),
        .ir_we_o(ir_we_a), .mc_busy_o(busy_a), .mc_timeout_o(to_a)
`ifdef HAZ_PERF_CNT_EN
        , .cnt_load_o(cl_a), .cnt_partial_o(cp_a), .cnt_mc_o(cm_a)
`endif
    );

    hazard_fwd_unit #(
        .NUM_RPORTS(NRP), .NUM_FWD(NF), .REG_AW(AW), .LOAD_RDY_STAGE(LDRDY),
        .MC_LAT(LAT_B), .CNT_W(CW)
    ) dut_b (
        .clk_i(clk), .resetn_i(resetn), .rd_valid_i(rd_valid), .rd_addr_i(rd_addr),
        .stg_waddr_i(stg_waddr), .stg_wen_i(stg_wen), .stg_load_i(stg_load),
        .id_valid_i(id_valid), .id_uses_hilo_i(id_uses_hilo), .mc_start_i(mc_start),
        .mc_done_i(mc_done), .fwd_sel_o(sel_b), .stall_id_o(stall_b), .pc_we_o(pc_we_b),
        .ir_we_o(ir_we_b), .mc_busy_o(busy_b), .mc_timeout_o(to_b)
`ifdef HAZ_PERF_CNT_EN
        , .cnt_load_o(cl_b), .cnt_partial_o(cp_b), .cnt_mc_o(cm_b)
`endif
    );

    // Reference: the youngest producer writing the register supplies it; stalls follow from it.
    task automatic model_fwd(output logic [NRP*SELW-1:0] sel, output logic st);
        sel = '0;
        st  = 1'b0;
        for (int k = 0; k < NRP; k++) begin
            int a;
            bit found;
            a = int'(rd_addr[k*AW +: AW]);
            found = 0;
            for (int j = 0; j < NF; j++) begin
                if (!found && rd_valid[k] && a != 0 && a == int'(stg_waddr[j*AW +: AW]) &&
                    stg_wen[j*4 +: 4] != 4'h0) begin
                    found = 1;
                    sel[k*SELW +: SELW] = SELW'(j + 1);
                    if (stg_load[j] && j < LDRDY) st = 1'b1;
                    if (stg_wen[j*4 +: 4] != 4'hF) st = 1'b1;
                end
            end
        end
    endtask

    task automatic clear_inputs();
        rd_valid = '0; rd_addr = '0; stg_waddr = '0; stg_wen = '0; stg_load = '0;
        id_valid = 0; id_uses_hilo = 0; mc_start = 0; mc_done = 0;
    endtask

    task automatic set_stage(input int j, input int wa, input logic [3:0] we, input logic ld);
        stg_waddr[j*AW +: AW] = AW'(wa);
        stg_wen[j*4 +: 4]     = we;
        stg_load[j]           = ld;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++;
        if (busy_a !== 1'b0 || to_a !== 1'b0 || busy_b !== 1'b0 || to_b !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mc: busy=%b/%b timeout=%b/%b expected all 0", busy_a, busy_b,
                     to_a, to_b);
        end
        n_cmp++;
        if (sel_a !== '0 || stall_a !== 1'b0 || pc_we_a !== 1'b1 || ir_we_a !== 1'b1) begin
            n_err++;
            $display("FAIL reset_comb: sel=%0h stall=%b pc_we=%b ir_we=%b expected 0 0 1 1",
                     sel_a, stall_a, pc_we_a, ir_we_a);
        end
    endtask

    task automatic test_priority();
        clear_inputs();
        rd_valid = 2'b01;
        rd_addr[0 +: AW] = 5'd8;
        for (int j = 0; j < NF; j++) set_stage(j, 8, 4'hF, 1'b0);
        #1;
        n_cmp++;
        if (sel_a[0 +: SELW] !== 2'd1 || stall_a !== 1'b0) begin
            n_err++;
            $display("FAIL prio_youngest: sel=%0d stall=%b expected 1 0", sel_a[0 +: SELW], stall_a);
        end
        set_stage(0, 8, 4'h0, 1'b0);
        #1;
        n_cmp++;
        if (sel_a[0 +: SELW] !== 2'd2 || stall_a !== 1'b0) begin
            n_err++;
            $display("FAIL prio_next: sel=%0d stall=%b expected 2 0", sel_a[0 +: SELW], stall_a);
        end
    endtask

    task automatic test_load_use();
        clear_inputs();
        rd_valid = 2'b10;
        rd_addr[AW +: AW] = 5'd9;
        set_stage(0, 9, 4'hF, 1'b1);
        #1;
        n_cmp++;
        if (stall_a !== 1'b1 || pc_we_a !== 1'b0 || ir_we_a !== 1'b0) begin
            n_err++;
            $display("FAIL load_use_s0: stall=%b pc_we=%b ir_we=%b expected 1 0 0", stall_a,
                     pc_we_a, ir_we_a);
        end
        set_stage(0, 0, 4'h0, 1'b0);
        set_stage(2, 9, 4'hF, 1'b1);
        #1;
        n_cmp++;
        if (stall_a !== 1'b0 || sel_a[SELW +: SELW] !== 2'd3) begin
            n_err++;
            $display("FAIL load_use_s2: stall=%b sel=%0d expected 0 3", stall_a,
                     sel_a[SELW +: SELW]);
        end
        set_stage(1, 9, 4'hF, 1'b1);
        #1;
        n_cmp++;
        if (stall_a !== 1'b1 || sel_a[SELW +: SELW] !== 2'd2) begin
            n_err++;
            $display("FAIL load_use_s1: stall=%b sel=%0d expected 1 2", stall_a,
                     sel_a[SELW +: SELW]);
        end
    endtask

    task automatic test_partial_zero();
        clear_inputs();
        rd_valid = 2'b01;
        rd_addr[0 +: AW] = 5'd4;
        set_stage(1, 4, 4'b0011, 1'b0);
        #1;
        n_cmp++;
        if (stall_a !== 1'b1 || sel_a[0 +: SELW] !== 2'd2) begin
            n_err++;
            $display("FAIL partial_s1: stall=%b sel=%0d expected 1 2", stall_a, sel_a[0 +: SELW]);
        end
        set_stage(1, 0, 4'h0, 1'b0);
        set_stage(2, 4, 4'b1100, 1'b0);
        #1;
        n_cmp++;
        if (stall_a !== 1'b1) begin
            n_err++;
            $display("FAIL partial_s2: stall=%b expected 1", stall_a);
        end
        set_stage(2, 0, 4'h0, 1'b0);
        rd_addr[0 +: AW] = 5'd0;
        set_stage(0, 0, 4'hF, 1'b1);
        #1;
        n_cmp++;
        if (sel_a[0 +: SELW] !== 2'd0 || stall_a !== 1'b0) begin
            n_err++;
            $display("FAIL zero_reg: sel=%0d stall=%b expected 0 0", sel_a[0 +: SELW], stall_a);
        end
    endtask

    task automatic test_random_fwd();
        logic [3:0] wen_tab [6];
        logic [NRP*SELW-1:0] exp_sel;
        logic exp_st;
        wen_tab[0] = 4'hF; wen_tab[1] = 4'hF; wen_tab[2] = 4'h0;
        wen_tab[3] = 4'h3; wen_tab[4] = 4'hC; wen_tab[5] = 4'h1;
        do_reset();
        for (int it = 0; it < 300; it++) begin
            rd_valid = NRP'($urandom);
            for (int k = 0; k < NRP; k++) rd_addr[k*AW +: AW] = AW'($urandom_range(0, 3));
            for (int j = 0; j < NF; j++)
                set_stage(j, int'($urandom_range(0, 3)), wen_tab[$urandom_range(0, 5)],
                          1'($urandom));
            id_valid     = 1'($urandom);
            id_uses_hilo = 1'($urandom);
            #1;
            model_fwd(exp_sel, exp_st);
            n_cmp++;
            if (sel_a !== exp_sel || stall_a !== exp_st || pc_we_a !== ~exp_st ||
                ir_we_a !== ~exp_st) begin
                n_err++;
                $display("FAIL rand_fwd[%0d]: sel=%0h stall=%b pc_we=%b expected sel=%0h stall=%b",
                         it, sel_a, stall_a, pc_we_a, exp_sel, exp_st);
            end
            #1;
        end
        clear_inputs();
    endtask

    task automatic test_mc_handshake();
        do_reset();
        id_valid = 1; id_uses_hilo = 1;
        for (int c = 0; c <= 12; c++) begin
            logic exp_b;
            mc_start = (c == 0);
            mc_done  = (c == 10);
            exp_b    = (c >= 1 && c <= 10);
            #1;
            n_cmp++;
            if (busy_a !== exp_b || stall_a !== exp_b) begin
                n_err++;
                $display("FAIL mc_hs cycle %0d: busy=%b stall=%b expected %b", c, busy_a, stall_a,
                         exp_b);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (to_a !== 1'b0) begin
            n_err++;
            $display("FAIL mc_hs_timeout: timeout=%b expected 0", to_a);
        end
        clear_inputs();
    endtask

    task automatic test_watchdog();
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            mc_start = (c == 0);
            #1;
            n_cmp++;
            if (busy_b !== (c >= 1 && c <= LAT_B) || to_b !== (c > LAT_B)) begin
                n_err++;
                $display("FAIL watchdog cycle %0d: busy=%b timeout=%b expected %b %b", c, busy_b,
                         to_b, (c >= 1 && c <= LAT_B), (c > LAT_B));
            end
            @(negedge clk);
        end
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (to_b !== 1'b0) begin
            n_err++;
            $display("FAIL watchdog_clear: timeout=%b expected 0", to_b);
        end
        @(negedge clk);
        resetn = 1'b1;
        clear_inputs();
    endtask

    task automatic test_mc_random();
        int rem_a, rem_b;
        bit t_a, t_b;
        do_reset();
        rem_a = 0; rem_b = 0; t_a = 0; t_b = 0;
        for (int c = 0; c < 400; c++) begin
            logic eb_a, eb_b;
            mc_start     = ($urandom_range(0, 5) == 0);
            mc_done      = ($urandom_range(0, 7) == 0);
            id_valid     = 1'($urandom);
            id_uses_hilo = 1'($urandom);
            eb_a = (rem_a > 0);
            eb_b = (rem_b > 0);
            #1;
            n_cmp++;
            if (busy_a !== eb_a || to_a !== t_a || stall_a !== (id_valid & id_uses_hilo & eb_a)) begin
                n_err++;
                $display("FAIL mc_rand_a cycle %0d: busy=%b to=%b stall=%b expected %b %b %b", c,
                         busy_a, to_a, stall_a, eb_a, t_a, id_valid & id_uses_hilo & eb_a);
            end
            n_cmp++;
            if (busy_b !== eb_b || to_b !== t_b || stall_b !== (id_valid & id_uses_hilo & eb_b)) begin
                n_err++;
                $display("FAIL mc_rand_b cycle %0d: busy=%b to=%b stall=%b expected %b %b %b", c,
                         busy_b, to_b, stall_b, eb_b, t_b, id_valid & id_uses_hilo & eb_b);
            end
            // rem counts busy cycles still owed to the current op
            if (rem_a > 0) begin
                if (mc_done) rem_a = mc_start ? LAT_A : 0;
                else begin rem_a--; if (rem_a == 0) t_a = 1; end
            end else if (mc_start) rem_a = LAT_A;
            if (rem_b > 0) begin
                if (mc_done) rem_b = mc_start ? LAT_B : 0;
                else begin rem_b--; if (rem_b == 0) t_b = 1; end
            end else if (mc_start) rem_b = LAT_B;
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        mc_start = 1;
        @(negedge clk);
        mc_start = 0; id_valid = 1; id_uses_hilo = 1;
        #1;
        n_cmp++;
        if (busy_a !== 1'b1 || stall_a !== 1'b1) begin
            n_err++;
            $display("FAIL async_pre: busy=%b stall=%b expected 1 1", busy_a, stall_a);
        end
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if (busy_a !== 1'b0 || stall_a !== 1'b0 || pc_we_a !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset: busy=%b stall=%b pc_we=%b expected 0 0 1", busy_a,
                     stall_a, pc_we_a);
        end
        @(negedge clk);
        resetn = 1'b1;
        clear_inputs();
    endtask

`ifdef HAZ_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        rd_valid = 2'b10;
        rd_addr[AW +: AW] = 5'd9;
        set_stage(0, 9, 4'hF, 1'b1);
        repeat (5) @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++;
        if (cl_a !== CW'(5) || cp_a !== '0 || cm_a !== '0) begin
            n_err++;
            $display("FAIL perf_count: load=%0d partial=%0d mc=%0d expected 5 0 0", cl_a, cp_a,
                     cm_a);
        end
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (cl_a !== '0) begin
            n_err++;
            $display("FAIL perf_clear: load=%0d expected 0", cl_a);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask
`endif

    initial begin
        clear_inputs();
        test_reset();
        test_priority();
        test_load_use();
        test_partial_zero();
        test_random_fwd();
        test_mc_handshake();
        test_watchdog();
        test_mc_random();
        test_async_reset();
`ifdef HAZ_PERF_CNT_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
